// File: rtl/lsu_dmem_master_pkg.sv
// ============================================================================
// Module : lsu_dmem_master_pkg
// Brief  : Shared types, constants and helper functions for the load/store
//          unit: FSM state encoding, RV32I load funct3 codes, and access-size
//          decode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_dmem_master_pkg;

    // Datapath width of the core
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Access size from funct3; unused encodings fall back to a word access.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: f3_size = SZ_BYTE;
            3'b001, 3'b101: f3_size = SZ_HALF;
            default:        f3_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic f3_illegal(input logic [2:0] f3);
        f3_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_dmem_master_load_align.sv
// ============================================================================
// Module : lsu_load_align
// Brief  : Combinational load-data aligner. Shifts the addressed byte or
//          halfword lane of a memory word down to bit 0 and sign- or
//          zero-extends it according to the RV32I load funct3.
// Ports  : rdata_i  [XLEN] raw memory word
//          offset_i [2]    byte offset of the access within the word
//          funct3_i [3]    load funct3 (unused encodings behave as LW)
//          data_o   [XLEN] aligned, extended load data
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_load_align #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);
    import lsu_dmem_master_pkg::*;

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            F3_LH:   data_o = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}},           w_shifted[7:0]};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}},          w_shifted[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_dmem_master.sv
// ============================================================================
// Module : lsu_dmem_master
// Brief  : Load/store unit, master side of the DMEM port. Accepts one request
//          at a time from the MEM stage, drives registered byte strobes and
//          lane-replicated store data for a single REQ cycle, then returns a
//          one-cycle response with aligned/extended load data in RESP.
//          Accept -> resp_valid latency is 2 cycles; a new request may be
//          accepted during RESP for one request every 2 cycles.
// Ports  : clk, rst_n (async, active low)
//          req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : request
//          resp_valid/resp_rdata/resp_err                          : response
//          dmem_addr/dmem_ren/dmem_wen/dmem_wstrb/dmem_wdata/dmem_rdata
// Config : LSU_MISALIGN_EXC_EN - when defined, misaligned halfword/word and
//          illegal funct3 requests produce resp_err and never touch memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_dmem_master #(
    parameter int XLEN      = 32,
    parameter bit RESP_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_ren,
    output logic            dmem_wen,
    output logic [3:0]      dmem_wstrb,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata
);
    import lsu_dmem_master_pkg::*;

    lsu_state_e      state_q, state_d;
    logic            accept;
    lsu_size_e       size;
    logic [1:0]      offset;
    logic            req_err;
    logic [3:0]      strb;
    logic [XLEN-1:0] wdata_rep;

    logic [XLEN-1:0] dmem_addr_d;
    logic            dmem_ren_d, dmem_wen_d;
    logic [3:0]      dmem_wstrb_d;
    logic [XLEN-1:0] dmem_wdata_d;

    logic            we_q, err_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [XLEN-1:0] aligned;

    assign req_ready = (state_q != REQ);
    assign accept    = req_valid & req_ready;

    // Request decode. Halfwords drop a[0] and words drop a[1:0], so the
    // effective offset is always naturally aligned to the access size.
    always_comb begin
        size    = f3_size(req_funct3);
        offset  = 2'b00;
        strb    = 4'b1111;
        wdata_rep = req_wdata;
        case (size)
            SZ_BYTE: begin
                offset    = req_addr[1:0];
                strb      = 4'b0001 << req_addr[1:0];
                wdata_rep = {(XLEN/8){req_wdata[7:0]}};
            end
            SZ_HALF: begin
                offset    = {req_addr[1], 1'b0};
                strb      = 4'b0011 << {req_addr[1], 1'b0};
                wdata_rep = {(XLEN/16){req_wdata[15:0]}};
            end
            default: ;
        endcase
`ifdef LSU_MISALIGN_EXC_EN
        req_err = f3_illegal(req_funct3)
                | ((size == SZ_HALF) && req_addr[0])
                | ((size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
        req_err = 1'b0;
`endif
    end

    // dmem outputs are only non-zero in the cycle after an accept (REQ).
    always_comb begin
        dmem_addr_d  = '0;
        dmem_ren_d   = 1'b0;
        dmem_wen_d   = 1'b0;
        dmem_wstrb_d = 4'b0000;
        dmem_wdata_d = '0;
        if (accept) begin
            dmem_addr_d = {req_addr[XLEN-1:2], 2'b00};
            if (!req_err) begin
                dmem_ren_d = ~req_we;
                dmem_wen_d = req_we;
                if (req_we) begin
                    dmem_wstrb_d = strb;
                    dmem_wdata_d = wdata_rep;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = REQ;
            REQ:     state_d = RESP;
            RESP:    state_d = accept ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dmem_addr  <= '0;
            dmem_ren   <= 1'b0;
            dmem_wen   <= 1'b0;
            dmem_wstrb <= 4'b0000;
            dmem_wdata <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            dmem_addr  <= dmem_addr_d;
            dmem_ren   <= dmem_ren_d;
            dmem_wen   <= dmem_wen_d;
            dmem_wstrb <= dmem_wstrb_d;
            dmem_wdata <= dmem_wdata_d;
            if (accept) begin
                we_q  <= req_we;
                err_q <= req_err;
                f3_q  <= req_funct3;
                off_q <= offset;
            end
        end
    end

    lsu_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .rdata_i  (dmem_rdata),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .data_o   (aligned)
    );

    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid & err_q;

    // Memory read data is only meaningful in RESP of a good load.
    always_comb begin
        resp_rdata = '0;
        if (RESP_ZERO) begin
            if (resp_valid && !we_q && !err_q) resp_rdata = aligned;
        end else begin
            if (!err_q) resp_rdata = aligned;
        end
    end

endmodule

`default_nettype wire
